// File: rtl/seq_det_pkg.sv
// Shared types and constants for the time-shared serial "1010" detector scheduler.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } sched_state_t;

  typedef enum logic [1:0] {
    S0   = 2'd0,
    S1   = 2'd1,
    S10  = 2'd2,
    S101 = 2'd3
  } det_state_t;

  localparam logic [3:0] PATTERN = 4'b1010;

endpackage

// File: rtl/pattern_match_core.sv
// Overlapping Mealy detector for PATTERN; state advances only on bit_en, clr restarts at S0.
module pattern_match_core
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic bit_en,
  input  logic bit_in,
  output logic match
);

  det_state_t r_state;
  det_state_t w_next_state;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_state <= S0;
    end else if (bit_en) begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    match        = 1'b0;
    case (r_state)
      S0:   w_next_state = bit_in ? S1 : S0;
      S1:   w_next_state = bit_in ? S1 : S10;
      S10:  w_next_state = bit_in ? S101 : S0;
      S101: begin
        // Overlap: the trailing "10" of a match is the prefix of the next one.
        if (bit_in == PATTERN[0]) begin
          w_next_state = S10;
          match        = bit_en;
        end else begin
          w_next_state = S1;
        end
      end
      default: w_next_state = S0;
    endcase
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler feeding requester words MSB-first through one shared "1010" detector.
// Optional SEQ_DET_PERF_CNT_EN adds a saturating total_matches counter port.
module seq_detect_scheduler
  import seq_det_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = 8,
  parameter int TOT_W   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*WORD_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]    resp_id,
  output logic [$clog2(WORD_W+1)-1:0]   resp_count,
  output logic                          resp_hit,
  output logic                          busy
`ifdef SEQ_DET_PERF_CNT_EN
  ,
  output logic [TOT_W-1:0]              total_matches
`endif
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int BIT_W = $clog2(WORD_W);
  localparam logic [ID_W:0] NREQ = (ID_W + 1)'(NUM_REQ);

  sched_state_t      r_state;
  sched_state_t      w_next_state;
  logic [WORD_W-1:0] r_shift;
  logic [ID_W-1:0]   r_id;
  logic [CNT_W-1:0]  r_count;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [ID_W-1:0]   r_last_grant;

  logic              w_grant_found;
  logic [ID_W-1:0]   w_grant_idx;
  logic [ID_W:0]     w_cand;
  logic              w_accept;
  logic              w_last_bit;
  logic              w_resp_fire;
  logic              w_match;

  // Search starts one past the last served requester so every requester gets a turn.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = {1'b0, r_last_grant} + (ID_W + 1)'(k);
      if (w_cand >= NREQ) w_cand = w_cand - NREQ;
      if (!w_grant_found && req_valid[w_cand[ID_W-1:0]]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_cand[ID_W-1:0];
      end
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // req_ready is a one-hot grant raised only in IDLE, resp_valid holds its fields until resp_ready.
  always_comb begin
    req_ready = '0;
    if (r_state == IDLE && w_grant_found) req_ready[w_grant_idx] = 1'b1;
  end

  assign w_accept    = (r_state == IDLE) && w_grant_found;
  assign w_last_bit  = (r_bit_cnt == BIT_W'(WORD_W - 1));
  assign w_resp_fire = (r_state == RESP) && resp_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept)    w_next_state = SHIFT;
      SHIFT:   if (w_last_bit)  w_next_state = RESP;
      RESP:    if (resp_ready)  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift      <= '0;
      r_id         <= '0;
      r_count      <= '0;
      r_bit_cnt    <= '0;
      r_last_grant <= ID_W'(NUM_REQ - 1);
    end else begin
      if (w_accept) begin
        r_shift   <= req_data[w_grant_idx*WORD_W +: WORD_W];
        r_id      <= w_grant_idx;
        r_count   <= '0;
        r_bit_cnt <= '0;
      end else if (r_state == SHIFT) begin
        r_shift   <= {r_shift[WORD_W-2:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 1'b1;
        if (w_match) r_count <= r_count + 1'b1;
      end
      if (w_resp_fire) r_last_grant <= r_id;
    end
  end

  pattern_match_core u_core (
    .clk    (clk),
    .reset  (reset),
    .clr    (w_accept),
    .bit_en (r_state == SHIFT),
    .bit_in (r_shift[WORD_W-1]),
    .match  (w_match)
  );

  assign resp_valid = (r_state == RESP);
  assign resp_id    = r_id;
  assign resp_count = r_count;
  assign resp_hit   = |r_count;
  assign busy       = (r_state != IDLE);

`ifdef SEQ_DET_PERF_CNT_EN
  logic [TOT_W-1:0] r_total;
  logic [TOT_W:0]   w_total_sum;

  // One extra sum bit catches the carry that triggers saturation.
  assign w_total_sum = {1'b0, r_total} + (TOT_W + 1)'(r_count);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_total <= '0;
    end else if (w_resp_fire) begin
      r_total <= w_total_sum[TOT_W] ? '1 : w_total_sum[TOT_W-1:0];
    end
  end

  assign total_matches = r_total;
`endif

endmodule
